// File: rtl/spi_con_pkg.sv
// Shared constants and types for the parallel-line SPI link.
// Used by both the transmitter and the receiver.
package spi_con_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LINES      = 6;

  typedef enum logic {
    IDLE,
    RECV
  } state_e;

  typedef logic [DEF_LINES-1:0][DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop pin synchronizer with per-bit reset value.
// All bits share one depth so bundled pins stay aligned.
module spi_pin_sync #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [DEPTH-1:0][WIDTH-1:0] chain_q;
  logic [DEPTH-1:0][WIDTH-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d_in};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      chain_q <= {DEPTH{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_out = chain_q[DEPTH-1];

endmodule

// File: rtl/spi_recv_con.sv
// Peripheral-side receiver for the parallel-line SPI link.
// Oversamples CS/DCLK/data and emits one word per DATA_WIDTH edges.
module spi_recv_con
  import spi_con_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LINES       = DEF_LINES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [LINES-1:0]                 chip_data_in,
  input  logic                             chip_clk_in,
  input  logic                             chip_sel_in,
  output logic [LINES-1:0][DATA_WIDTH-1:0] data_out,
  output logic                             data_valid_out,
  output logic                             frame_err_out
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int SW = LINES + 2;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  // CS idles high, DCLK and data idle low
  localparam logic [SW-1:0] SYNC_RST = {1'b1, {(SW-1){1'b0}}};

  typedef logic [LINES-1:0][DATA_WIDTH-1:0] lanes_t;

  logic [SW-1:0] pins;
  logic [SW-1:0] pins_s;

  assign pins = {chip_sel_in, chip_clk_in, chip_data_in};

  spi_pin_sync #(
    .WIDTH  (SW),
    .DEPTH  (SYNC_STAGES),
    .RST_VAL(SYNC_RST)
  ) u_sync (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .d_in  (pins),
    .q_out (pins_s)
  );

  logic             clk_prev_q, clk_prev_d;
  logic             rise_q, rise_d;
  logic             cs_q, cs_d;
  logic [LINES-1:0] dat_q, dat_d;

  // Edge-detect stage: keeps cs/data aligned with the rise flag
  always_comb begin
    clk_prev_d = pins_s[LINES];
    rise_d     = pins_s[LINES] & ~clk_prev_q;
    cs_d       = pins_s[LINES+1];
    dat_d      = pins_s[LINES-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      cs_q       <= 1'b1;
      dat_q      <= '0;
    end else begin
      clk_prev_q <= clk_prev_d;
      rise_q     <= rise_d;
      cs_q       <= cs_d;
      dat_q      <= dat_d;
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  lanes_t        shift_q, shift_d;
  lanes_t        shift_nxt;
  lanes_t        data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      shift_nxt[i] = {shift_q[i][DATA_WIDTH-2:0], dat_q[i]};
    end
    unique case (state_q)
      IDLE: begin
        if (!cs_q) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        // CS release takes priority over a coincident edge
        if (cs_q) begin
          state_d = IDLE;
          err_d   = (cnt_q != '0);
        end else if (rise_q) begin
          shift_d = shift_nxt;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            data_d  = shift_nxt;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign frame_err_out  = err_q;

endmodule

// File: tb/tb_spi_recv_con.sv
// Directed bench for spi_recv_con with default parameters.
// Bit-bangs CS/DCLK/data and checks words, pulses and latency.
module tb_spi_recv_con;
  import spi_con_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   sdat = '0;
  logic         sclk = 1'b0;
  logic         scs = 1'b1;
  logic [5:0][7:0] dout;
  logic         dvalid;
  logic         ferr;

  spi_recv_con dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .chip_data_in  (sdat),
    .chip_clk_in   (sclk),
    .chip_sel_in   (scs),
    .data_out      (dout),
    .data_valid_out(dvalid),
    .frame_err_out (ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    vcnt = 0;
  int    ecnt = 0;
  int    ovl = 0;
  int    vcyc = 0;
  int    edge_cyc = 0;
  word_t capq[$];

  always @(negedge clk) begin
    if (dvalid) begin
      vcnt++;
      vcyc = cyc;
      capq.push_back(dout);
    end
    if (ferr) ecnt++;
    if (dvalid && ferr) ovl++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input word_t w, input int nb, input int ph);
    for (int b = 7; b > 7 - nb; b--) begin
      sclk = 1'b0;
      for (int i = 0; i < 6; i++) sdat[i] = w[i][b];
      tick(ph);
      sclk = 1'b1;
      edge_cyc = cyc + 1;
      tick(ph);
    end
    sclk = 1'b0;
  endtask

  task automatic frame(input word_t w, input int ph);
    scs = 1'b0;
    tick(10);
    send_bits(w, 8, ph);
    tick(10);
    scs = 1'b1;
    tick(10);
  endtask

  word_t w, w2, w3;
  int    v0, e0;

  initial begin
    tick(3);
    rst = 1'b0;
    chk("rst_data", dout, 0);
    chk("rst_valid", dvalid, 0);
    chk("rst_err", ferr, 0);
    tick(5);

    // single word, 100-cycle DCLK period
    w = {8'h7E, 8'h81, 8'h00, 8'hFF, 8'h3C, 8'hA5};
    v0 = vcnt; e0 = ecnt;
    frame(w, 50);
    chk("w1_cnt", vcnt - v0, 1);
    chk("w1_data", dout, w);
    chk("w1_lat", vcyc, edge_cyc + 3);
    chk("w1_err", ecnt - e0, 0);

    // three back-to-back words
    v0 = vcnt;
    capq.delete();
    scs = 1'b0;
    tick(10);
    w = '0; w[0] = 8'h01;
    send_bits(w, 8, 6);
    w[0] = 8'h02;
    send_bits(w, 8, 6);
    w[0] = 8'h03;
    send_bits(w, 8, 6);
    tick(10);
    scs = 1'b1;
    tick(10);
    chk("b2b_cnt", vcnt - v0, 3);
    chk("b2b_qsz", capq.size(), 3);
    if (capq.size() == 3) begin
      chk("b2b_w0", capq[0][0], 8'h01);
      chk("b2b_w1", capq[1][0], 8'h02);
      chk("b2b_w2", capq[2][0], 8'h03);
    end
    chk("b2b_data", dout, 48'h03);
    chk("b2b_err", ecnt - e0, 0);

    // CS raised after 5 edges
    v0 = vcnt; e0 = ecnt;
    w = {6{8'hFF}};
    scs = 1'b0;
    tick(10);
    send_bits(w, 5, 6);
    tick(6);
    scs = 1'b1;
    tick(15);
    chk("abort_err", ecnt - e0, 1);
    chk("abort_valid", vcnt - v0, 0);
    chk("abort_data", dout, 48'h03);
    w2 = {6{8'h5A}};
    frame(w2, 6);
    chk("post_abort_cnt", vcnt - v0, 1);
    chk("post_abort_data", dout, w2);
    chk("post_abort_err", ecnt - e0, 1);

    // edges with CS high are ignored
    v0 = vcnt; e0 = ecnt;
    send_bits(w, 8, 6);
    tick(10);
    chk("cs_hi_valid", vcnt - v0, 0);
    chk("cs_hi_err", ecnt - e0, 0);
    chk("cs_hi_data", dout, w2);

    // reset after 4 edges of a frame
    scs = 1'b0;
    tick(10);
    send_bits(w, 4, 6);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_data", dout, 0);
    chk("mid_rst_valid", dvalid, 0);
    chk("mid_rst_err", ferr, 0);
    tick(10);
    scs = 1'b1;
    tick(10);
    chk("mid_rst_np_v", vcnt - v0, 0);
    chk("mid_rst_np_e", ecnt - e0, 0);
    w3 = {6{8'hC3}};
    frame(w3, 6);
    chk("rst_frame_cnt", vcnt - v0, 1);
    chk("rst_frame_data", dout, w3);
    chk("rst_frame_err", ecnt - e0, 0);

    // minimum 4-cycle DCLK phases
    v0 = vcnt;
    w = {8'h96, 8'h69, 8'h0F, 8'hF0, 8'h55, 8'hAA};
    frame(w, 4);
    chk("min_cnt", vcnt - v0, 1);
    chk("min_data", dout, w);
    chk("min_lat", vcyc, edge_cyc + 3);
    chk("overlap", ovl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
